fc_neuron_mac: RTL and testbench
================================

FC_NEURON_MAC -- requirements
Module: fc_neuron_mac

Interface
REQ-001 SHALL have parameter N_IN, default 8: number of pixel/weight pairs per neuron.
REQ-002 SHALL have parameter DATA_W, default 8: width of each pixel, weight and result.
REQ-003 SHALL have parameter ACC_W, default 20: signed accumulator width.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1: operand set presented.
REQ-007 SHALL have port in_ready, output, 1: block can accept an operand set.
REQ-008 SHALL have port pixels, input, N_IN x DATA_W: unsigned pooled pixels, element i in slice i.
REQ-009 SHALL have port weights, input, N_IN*DATA_W: signed weights, weight i in bits [DATA_W*i +: DATA_W].
REQ-010 SHALL have port bias, input, ACC_W: signed bias.
REQ-011 SHALL have port out_valid, output, 1: result valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-013 SHALL have port result, output, DATA_W: activated, saturated neuron output.

Function
REQ-014 SHALL implement FSM states IDLE, MAC and OUT.
REQ-015 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in OUT.
REQ-016 In IDLE with in_valid=1, SHALL register pixels and weights, load acc with sign-extended bias, clear idx to 0 and go to MAC; operands SHALL NOT be sampled again until the next acceptance.
REQ-017 In MAC, SHALL each cycle add signed({1'b0,pixel[idx]}) * signed(weight[idx]), sign-extended to ACC_W, to acc, then increment idx.
REQ-018 When idx==N_IN-1 in MAC, SHALL register activate(acc + final product) into result and go to OUT.
REQ-019 SHALL assert out_valid exactly N_IN cycles after the accepting edge (one MAC per cycle, no bubbles).
REQ-020 In OUT, SHALL hold result and out_valid stable until out_ready=1, then go to IDLE on that edge; out_ready outside OUT SHALL be ignored.
REQ-021 in_valid during MAC or OUT SHALL be ignored (no overlap; throughput one set per N_IN+2 cycles minimum).
REQ-022 The accumulator SHALL never wrap; ACC_W < 2*DATA_W+$clog2(N_IN)+1 SHALL be a elaboration-time error.
REQ-023 N_IN=1 SHALL be legal: a single MAC cycle, then OUT.

Reset
REQ-024 rst=1 SHALL on the next edge force IDLE, acc=0, idx=0, result=0, out_valid=0, in_ready=1, overriding any handshake on that edge.
REQ-025 rst mid-MAC or mid-OUT SHALL discard the operation; no out_valid pulse SHALL follow.

Configuration
REQ-026 Macro FC_RELU_EN defined: activate SHALL clamp acc<0 to 0 and acc>2^DATA_W-1 to 2^DATA_W-1, result unsigned.
REQ-027 Macro FC_RELU_EN undefined: activate SHALL saturate acc to signed range [-2^(DATA_W-1), 2^(DATA_W-1)-1], result two's complement.

Structure
REQ-028 Package fc_pkg SHALL hold the FSM state enum typedef and a localparam function for minimum ACC_W.
REQ-029 Activation/saturation SHALL be a combinational sub-module fc_act, parametrised by DATA_W and ACC_W, instantiated once.

Verification
REQ-030 Defaults, pixels all 1, weights all 1, bias 0 -> out_valid 8 cycles after acceptance, result=8.
REQ-031 FC_RELU_EN, pixels all 255, weights all 127, bias 0 -> acc=259080, result=255; without macro -> result=127.
REQ-032 FC_RELU_EN, pixels all 10, weights all -1, bias 5 -> acc=-75, result=0; without macro -> result=-75 (0xB5).
REQ-033 out_ready held 0 for 5 cycles in OUT, in_valid=1 throughout -> result stable, in_ready=0, second set accepted only the cycle after out_ready=1.
REQ-034 rst pulsed at MAC idx=3 -> next cycle IDLE, result=0, out_valid never asserts for that set; new set completes normally.
REQ-035 N_IN=1, pixel 3, weight -2, bias 10, no macro -> result=4 one cycle after acceptance.

Source files
------------

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - FSM state type and accumulator sizing helper for fc_neuron_mac
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fc_state_t;

  // Narrowest accumulator that cannot wrap: full product plus growth over n_in terms plus bias headroom.
  function automatic int fc_min_acc_w(input int data_w, input int n_in);
    return 2 * data_w + $clog2(n_in) + 1;
  endfunction

endpackage

// File: rtl/fc_act.sv
// rtl/fc_act.sv - combinational activation: ReLU clamp to unsigned range when FC_RELU_EN, else signed saturation
module fc_act #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] y
);

`ifdef FC_RELU_EN
  localparam logic signed [ACC_W-1:0] HI = ACC_W'((2 ** DATA_W) - 1);

  always_comb begin
    if (acc[ACC_W-1])
      y = '0;
    else if (acc > HI)
      y = '1;
    else
      y = acc[DATA_W-1:0];
  end
`else
  localparam logic signed [ACC_W-1:0] HI = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] LO = ~HI;

  always_comb begin
    if (acc > HI)
      y = HI[DATA_W-1:0];
    else if (acc < LO)
      y = LO[DATA_W-1:0];
    else
      y = acc[DATA_W-1:0];
  end
`endif

endmodule

// File: rtl/fc_neuron_mac.sv
// rtl/fc_neuron_mac.sv - sequential one-MAC-per-cycle neuron with bias and activation (FC_RELU_EN selects ReLU)
module fc_neuron_mac
  import fc_pkg::*;
#(
  parameter int N_IN   = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_IN-1:0][DATA_W-1:0]   pixels,
  input  logic [N_IN*DATA_W-1:0]        weights,
  input  logic [ACC_W-1:0]              bias,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             result
);

  localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PROD_W = 2 * DATA_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  generate
    if (ACC_W < fc_min_acc_w(DATA_W, N_IN)) begin : g_acc_w_check
      $error("fc_neuron_mac: ACC_W is too narrow for DATA_W and N_IN");
    end
  endgenerate

  fc_state_t state, state_next;

  logic [N_IN*DATA_W-1:0] pix_q;
  logic [N_IN*DATA_W-1:0] w_q;
  logic signed [ACC_W-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic [DATA_W-1:0] result_q;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] sum;
  logic [DATA_W-1:0] act_y;

  // Operands shift down one element per MAC, so element 0 is always pixel[idx]/weight[idx].
  always_comb begin
    prod = PROD_W'($signed({1'b0, pix_q[DATA_W-1:0]})) * PROD_W'($signed(w_q[DATA_W-1:0]));
    sum  = acc + ACC_W'(prod);
  end

  fc_act #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_act (
    .acc (sum),
    .y   (act_y)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = MAC;
      MAC:     if (idx == LAST_IDX) state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q    <= '0;
      w_q      <= '0;
      acc      <= '0;
      idx      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pix_q <= pixels;
            w_q   <= weights;
            acc   <= $signed(bias);
            idx   <= '0;
          end
        end
        MAC: begin
          acc   <= sum;
          idx   <= idx + IDX_W'(1);
          pix_q <= pix_q >> DATA_W;
          w_q   <= w_q >> DATA_W;
          if (idx == LAST_IDX)
            result_q <= act_y;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_fc_neuron_mac.sv
// tb/tb_fc_neuron_mac.sv - directed self-checking bench for fc_neuron_mac (expectations follow FC_RELU_EN)
module tb_fc_neuron_mac;

`ifdef FC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid, in_ready, out_valid, out_ready;
  logic [7:0][7:0]  pixels;
  logic [63:0]      weights;
  logic [19:0]      bias;
  logic [7:0]       result;

  logic             in_valid1, in_ready1, out_valid1, out_ready1;
  logic [0:0][7:0]  pixels1;
  logic [7:0]       weights1;
  logic [19:0]      bias1;
  logic [7:0]       result1;

  int checks = 0;
  int errors = 0;

  fc_neuron_mac #(.N_IN(8), .DATA_W(8), .ACC_W(20)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .pixels(pixels), .weights(weights), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  fc_neuron_mac #(.N_IN(1), .DATA_W(8), .ACC_W(20)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .pixels(pixels1), .weights(weights1), .bias(bias1),
    .out_valid(out_valid1), .out_ready(out_ready1), .result(result1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_released"}, out_valid, 0);
    check({tag, "_idle_ready"}, in_ready, 1);
  endtask

  task automatic run_set(input string tag, input logic [63:0] pix, input logic [63:0] w,
                         input logic [19:0] b, input logic [7:0] exp);
    int cyc;
    pixels   = pix;
    weights  = w;
    bias     = b;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(cyc);
    check({tag, "_latency"}, cyc, 8);
    check({tag, "_result"}, result, exp);
    release_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int cyc;
    int seen;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; pixels = '0; weights = '0; bias = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; pixels1 = '0; weights1 = '0; bias1 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);

    run_set("ones", 64'h0101010101010101, 64'h0101010101010101, 20'h00000, 8'd8);
    run_set("pos_sat", 64'hFFFFFFFFFFFFFFFF, 64'h7F7F7F7F7F7F7F7F, 20'h00000, RELU ? 8'hFF : 8'h7F);
    run_set("neg", 64'h0A0A0A0A0A0A0A0A, 64'hFFFFFFFFFFFFFFFF, 20'h00005, RELU ? 8'h00 : 8'hB5);
    run_set("mixed", 64'h0807060504030201, 64'hFD02FD02FD02FD02, 20'd30, 8'd2);
    run_set("neg_sat", 64'hFFFFFFFFFFFFFFFF, 64'h8080808080808080, 20'h00000, RELU ? 8'h00 : 8'h80);
    run_set("bias_127", 64'hFFFFFFFFFFFFFFFF, 64'h0, 20'h0007F, 8'h7F);
    run_set("bias_128", 64'hFFFFFFFFFFFFFFFF, 64'h0, 20'h00080, RELU ? 8'h80 : 8'h7F);
    run_set("bias_m128", 64'h0, 64'h0, 20'hFFF80, RELU ? 8'h00 : 8'h80);

    // Output stall with a new operand set pending throughout.
    pixels = 64'h0101010101010101; weights = 64'h0101010101010101; bias = '0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    pixels = 64'h0807060504030201; weights = 64'hFD02FD02FD02FD02; bias = 20'd30;
    wait_out(cyc);
    check("stall_latency", cyc, 8);
    for (int i = 0; i < 5; i++) begin
      check("stall_result", result, 8);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_drop_valid", out_valid, 0);
    check("stall_idle_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("second_accepted", in_ready, 0);
    wait_out(cyc);
    check("second_latency", cyc, 8);
    check("second_result", result, 2);
    release_out("second");

    // Reset in the middle of a MAC sequence.
    pixels = 64'hFFFFFFFFFFFFFFFF; weights = 64'h7F7F7F7F7F7F7F7F; bias = '0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("midrst_no_pulse", seen, 0);
    run_set("after_rst", 64'h0101010101010101, 64'h0101010101010101, 20'h00000, 8'd8);

    // Single-input neuron.
    pixels1 = 8'd3; weights1 = 8'hFE; bias1 = 20'd10;
    in_valid1 = 1'b1;
    check("n1_in_ready", in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    check("n1_busy", in_ready1, 0);
    @(posedge clk); #1;
    check("n1_out_valid", out_valid1, 1);
    check("n1_result", result1, 4);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check("n1_released", out_valid1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
